// File: rtl/seq_fsm.sv
// rtl/seq_fsm.sv - one-hot S0..S10 program sequencer with stall, completion status and run counter
// Optional single-step gating of S1..S9 under macro SEQ_FSM_SINGLE_STEP_EN.
module seq_fsm #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
`ifdef SEQ_FSM_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [10:0]        state,
  output logic [10:0]        next_state,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] run_count,
  output logic               illegal
);

  typedef enum logic [10:0] {
    S0  = 11'h001,
    S1  = 11'h002,
    S2  = 11'h004,
    S3  = 11'h008,
    S4  = 11'h010,
    S5  = 11'h020,
    S6  = 11'h040,
    S7  = 11'h080,
    S8  = 11'h100,
    S9  = 11'h200,
    S10 = 11'h400
  } state_t;

  logic [10:0] state_q;
  logic [10:0] state_n;
  logic        advance;
  logic        legal;
  logic        complete;

`ifdef SEQ_FSM_SINGLE_STEP_EN
  assign advance = ~hold & step;
`else
  assign advance = ~hold;
`endif

  // A word with exactly one bit set is a legal state.
  assign legal = (state_q != 11'd0) && ((state_q & (state_q - 11'd1)) == 11'd0);

  always_comb begin
    state_n = S0;
    case (state_q)
      S0:      state_n = start   ? S1  : S0;
      S1:      state_n = advance ? S2  : S1;
      S2:      state_n = advance ? S3  : S2;
      S3:      state_n = advance ? S4  : S3;
      S4:      state_n = advance ? S5  : S4;
      S5:      state_n = advance ? S6  : S5;
      S6:      state_n = advance ? S7  : S6;
      S7:      state_n = advance ? S8  : S7;
      S8:      state_n = advance ? S9  : S8;
      S9:      state_n = advance ? S10 : S9;
      S10:     state_n = start   ? S1  : S0;
      default: state_n = S0;
    endcase
  end

  // Exact-match decode keeps busy/done low for any non-one-hot word.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S1, S2, S3, S4, S5, S6, S7, S8, S9: busy = 1'b1;
      S10:                                done = 1'b1;
      default: ;
    endcase
  end

  assign complete = (state_q == S9) && advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S0;
      run_count <= '0;
      illegal   <= 1'b0;
    end else begin
      state_q <= state_n;
      if (complete)
        run_count <= run_count + 1'b1;
      if (!legal)
        illegal <= 1'b1;
    end
  end

  assign state      = state_q;
  assign next_state = state_n;

endmodule

// File: tb/tb_seq_fsm.sv
// tb/tb_seq_fsm.sv - directed self-checking bench for seq_fsm (COUNT_W = 2)
module tb_seq_fsm;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hold;
`ifdef SEQ_FSM_SINGLE_STEP_EN
  logic        step;
`endif
  logic [10:0] state;
  logic [10:0] next_state;
  logic        busy;
  logic        done;
  logic [1:0]  run_count;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  seq_fsm #(.COUNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hold       (hold),
`ifdef SEQ_FSM_SINGLE_STEP_EN
    .step       (step),
`endif
    .state      (state),
    .next_state (next_state),
    .busy       (busy),
    .done       (done),
    .run_count  (run_count),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance negedge by negedge until state reaches target; returns cycles spent, or -1 on timeout.
  task automatic wait_state(input logic [10:0] target, input int limit, output int n);
    n = 0;
    while (state !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (state !== target) begin
      check("wait_state_timeout", {21'd0, state}, {21'd0, target});
      n = -1;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
`ifdef SEQ_FSM_SINGLE_STEP_EN
    step  = 1'b1;
`endif

    // reset then idle
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_state", {21'd0, state}, 32'h001);
      check("idle_next", {21'd0, next_state}, 32'h001);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_count", {30'd0, run_count}, 32'd0);
      check("idle_illegal", {31'd0, illegal}, 32'd0);
    end

    // single run
    start = 1'b1;
    #1 check("run_next_on_start", {21'd0, next_state}, 32'h002);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      check("run_state", {21'd0, state}, 32'(1 << i));
      check("run_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("run_s10_state", {21'd0, state}, 32'h400);
    check("run_s10_done", {31'd0, done}, 32'd1);
    check("run_s10_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("run_after_state", {21'd0, state}, 32'h001);
    check("run_after_count", {30'd0, run_count}, 32'd1);

    // hold in S4 for three cycles
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_reach_s4", {21'd0, state}, 32'h010);
    hold = 1'b1;
    #1 check("hold_next_c4", {21'd0, next_state}, 32'h010);
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      check("hold_state", {21'd0, state}, 32'h010);
      check("hold_next", {21'd0, next_state}, 32'h010);
    end
    hold = 1'b0;
    #1 check("hold_release_next", {21'd0, next_state}, 32'h020);
    wait_state(11'h400, 40, n);
    check("hold_run_cycles", 32'(n + 7), 32'd13);
    check("hold_count", {30'd0, run_count}, 32'd2);

    // back-to-back runs with counter wrap
    do_reset();
    start = 1'b1;
    @(negedge clk);
    for (int r = 1; r <= 5; r++) begin
      for (int i = 1; i <= 9; i++) begin
        check("b2b_state", {21'd0, state}, 32'(1 << i));
        @(negedge clk);
      end
      check("b2b_s10", {21'd0, state}, 32'h400);
      check("b2b_count", {30'd0, run_count}, 32'(r % 4));
      check("b2b_next_s1", {21'd0, next_state}, 32'h002);
      @(negedge clk);
    end
    check("b2b_no_idle", {21'd0, state}, 32'h002);
    start = 1'b0;
    wait_state(11'h001, 40, n);
    check("b2b_sixth_count", {30'd0, run_count}, 32'd2);

    // asynchronous reset mid-run in S6
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("areset_in_s6", {21'd0, state}, 32'h040);
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", {21'd0, state}, 32'h001);
    check("areset_count", {30'd0, run_count}, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("areset_stays_idle", {21'd0, state}, 32'h001);

    // illegal state recovery
    force dut.state_q = 11'h0C0;
    #1;
    check("illegal_next", {21'd0, next_state}, 32'h001);
    check("illegal_busy", {31'd0, busy}, 32'd0);
    check("illegal_done", {31'd0, done}, 32'd0);
    check("illegal_flag_before", {31'd0, illegal}, 32'd0);
    release dut.state_q;
    @(negedge clk);
    check("illegal_flag_set", {31'd0, illegal}, 32'd1);
    check("illegal_recovered", {21'd0, state}, 32'h001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal_run_s1", {21'd0, state}, 32'h002);
    wait_state(11'h400, 40, n);
    check("illegal_run_cycles", 32'(n + 1), 32'd10);
    check("illegal_run_done", {31'd0, done}, 32'd1);
    check("illegal_run_count", {30'd0, run_count}, 32'd1);
    check("illegal_sticky", {31'd0, illegal}, 32'd1);

    // start and hold together in S10: start wins
    hold  = 1'b1;
    start = 1'b1;
    #1 check("s10_start_wins", {21'd0, next_state}, 32'h002);
    @(negedge clk);
    start = 1'b0;
    hold  = 1'b0;
    check("s10_start_wins_state", {21'd0, state}, 32'h002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
